// File: rtl/picomips_pkg.sv
// picoMIPS shared encodings: opcodes, ALU function codes and the decoder control bundle.
// Shared with the ALU and the assembler tables.
package picomips_pkg;

  localparam logic [5:0] OP_NOP  = 6'b111111;
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_SUBI = 6'b000011;
  localparam logic [5:0] OP_MUL  = 6'b000100;
  localparam logic [5:0] OP_MULI = 6'b000101;
  localparam logic [5:0] OP_ADDF = 6'b000110;
  localparam logic [5:0] OP_BAT  = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b001000;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;

  typedef struct packed {
    logic       pcincr;
    logic       pcabs;
    logic       pcrel;
    logic [2:0] alufunc;
    logic       imm;
    logic       fetch;
    logic       w;
  } ctrl_t;

  // NOP control word; every decode starts from here.
  localparam ctrl_t CTRL_NOP = '{pcincr: 1'b1, pcabs: 1'b0, pcrel: 1'b0,
                                 alufunc: ALU_PASS, imm: 1'b0, fetch: 1'b0, w: 1'b0};

endpackage

// File: rtl/picomips_decoder_bstus_sync.sv
// Two-flop synchroniser for the branch-status switch, with an optional debouncer
// enabled by defining BSTUS_DEBOUNCE_EN.
module bstus_sync #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nReset,
  input  logic d,
  output logic q
);

  logic s1, s2;

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end

`ifdef BSTUS_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          qr;

  // Count consecutive samples that disagree with the accepted value; any agreeing
  // sample restarts the count.
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      cnt <= '0;
      qr  <= 1'b0;
    end else if (s2 == qr) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      qr  <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end

  assign q = qr;
`else
  logic [31:0] unused_dbc;
  assign unused_dbc = DEBOUNCE_CYCLES;
  assign q = s2;
`endif

endmodule

// File: rtl/picomips_decoder.sv
// picoMIPS instruction decoder: combinational opcode decode plus the synchronised
// branch-status input used by BAT. Optional debounce: BSTUS_DEBOUNCE_EN.
module picomips_decoder
  import picomips_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [5:0] opcode,
  input  logic [3:0] flags,
  input  logic       Bcond,
  input  logic       Bstus,
  output logic       PCincr,
  output logic       PCabsbranch,
  output logic       PCrelbranch,
  output logic [2:0] ALUfunc,
  output logic       imm,
  output logic       fetch,
  output logic       w
);

  logic  bstus_q;
  ctrl_t ctrl;

  // Flags are reserved for future conditional branches.
  logic unused_flags;
  assign unused_flags = ^flags;

  bstus_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bstus_sync (
    .clk    (clk),
    .nReset (nReset),
    .d      (Bstus),
    .q      (bstus_q)
  );

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_ADD:  begin ctrl.w = 1'b1; ctrl.alufunc = ALU_ADD; end
      OP_ADDI: begin ctrl.w = 1'b1; ctrl.alufunc = ALU_ADD; ctrl.imm = 1'b1; end
      OP_SUB:  begin ctrl.w = 1'b1; ctrl.alufunc = ALU_SUB; end
      OP_SUBI: begin ctrl.w = 1'b1; ctrl.alufunc = ALU_SUB; ctrl.imm = 1'b1; end
      OP_MUL:  begin ctrl.w = 1'b1; ctrl.alufunc = ALU_MUL; end
      OP_MULI: begin ctrl.w = 1'b1; ctrl.alufunc = ALU_MUL; ctrl.imm = 1'b1; end
      OP_ADDF: begin ctrl.w = 1'b1; ctrl.alufunc = ALU_ADD; ctrl.fetch = 1'b1; end
      OP_J:    begin ctrl.pcincr = 1'b0; ctrl.pcabs = 1'b1; end
      // Match holds/branches relative; a zero offset spins until the switch moves.
      OP_BAT:
        if (bstus_q == Bcond) begin
          ctrl.pcincr = 1'b0;
          ctrl.pcrel  = 1'b1;
        end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign PCincr      = ctrl.pcincr;
  assign PCabsbranch = ctrl.pcabs;
  assign PCrelbranch = ctrl.pcrel;
  assign ALUfunc     = ctrl.alufunc;
  assign imm         = ctrl.imm;
  assign fetch       = ctrl.fetch;
  assign w           = ctrl.w;

endmodule

// File: tb/tb_picomips_decoder.sv
// Directed bench for picomips_decoder (default build, debounce disabled).
module tb_picomips_decoder;

  logic       clk = 1'b0;
  logic       nReset;
  logic [5:0] opcode;
  logic [3:0] flags;
  logic       Bcond;
  logic       Bstus;
  logic       PCincr, PCabsbranch, PCrelbranch, imm, fetch, w;
  logic [2:0] ALUfunc;

  int checks = 0;
  int errors = 0;

  picomips_decoder #(.DEBOUNCE_CYCLES(16)) dut (
    .clk         (clk),
    .nReset      (nReset),
    .opcode      (opcode),
    .flags       (flags),
    .Bcond       (Bcond),
    .Bstus       (Bstus),
    .PCincr      (PCincr),
    .PCabsbranch (PCabsbranch),
    .PCrelbranch (PCrelbranch),
    .ALUfunc     (ALUfunc),
    .imm         (imm),
    .fetch       (fetch),
    .w           (w)
  );

  always #5 clk = ~clk;

  // {PCincr, PCabsbranch, PCrelbranch, ALUfunc, imm, fetch, w}
  localparam logic [8:0] E_NOP  = 9'b1_0_0_000_0_0_0;
  localparam logic [8:0] E_ADD  = 9'b1_0_0_001_0_0_1;
  localparam logic [8:0] E_ADDI = 9'b1_0_0_001_1_0_1;
  localparam logic [8:0] E_SUB  = 9'b1_0_0_010_0_0_1;
  localparam logic [8:0] E_SUBI = 9'b1_0_0_010_1_0_1;
  localparam logic [8:0] E_MUL  = 9'b1_0_0_011_0_0_1;
  localparam logic [8:0] E_MULI = 9'b1_0_0_011_1_0_1;
  localparam logic [8:0] E_ADDF = 9'b1_0_0_001_0_1_1;
  localparam logic [8:0] E_J    = 9'b0_1_0_000_0_0_0;
  localparam logic [8:0] E_HOLD = 9'b0_0_1_000_0_0_0;

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    #1;
    obs = {PCincr, PCabsbranch, PCrelbranch, ALUfunc, imm, fetch, w};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [5:0] o, input logic bc);
    opcode = o;
    Bcond  = bc;
  endtask

  initial begin
    nReset = 1'b0; opcode = 6'b111111; flags = 4'h0; Bcond = 1'b0; Bstus = 1'b1;
    #3;
    chk("reset_nop", E_NOP);
    op(6'b000111, 1'b0); chk("reset_bat_bc0", E_HOLD);
    tick();
    chk("reset_bat_held_after_edge", E_HOLD);

    // Release between edges; Bstus=1 reaches bstus_q after two edges.
    nReset = 1'b1;
    #1;
    chk("rel_bat_edge0", E_HOLD);
    tick();
    chk("rel_bat_edge1", E_HOLD);
    tick();
    chk("rel_bat_edge2", E_NOP);
    op(6'b000111, 1'b1); chk("bat_bc1_match", E_HOLD);

    op(6'b111111, 1'b0); chk("nop", E_NOP);
    op(6'b000000, 1'b0); chk("add", E_ADD);
    op(6'b000001, 1'b0); chk("addi", E_ADDI);
    op(6'b000010, 1'b0); chk("sub", E_SUB);
    op(6'b000011, 1'b0); chk("subi", E_SUBI);
    op(6'b000100, 1'b0); chk("mul", E_MUL);
    op(6'b000101, 1'b0); chk("muli", E_MULI);
    op(6'b000110, 1'b0); chk("addf", E_ADDF);
    op(6'b001000, 1'b0); chk("j", E_J);
    op(6'b101010, 1'b0); chk("undef_101010", E_NOP);
    op(6'b001001, 1'b1); chk("undef_001001", E_NOP);
    flags = 4'hF;
    op(6'b000000, 1'b1); chk("add_flags_ignored", E_ADD);
    op(6'b001000, 1'b1); chk("j_flags_ignored", E_J);
    flags = 4'h0;

    // Bstus 1->0 with Bcond=0: hold only from the 2nd edge.
    op(6'b000111, 1'b0);
    Bstus = 1'b0;
    #1;
    chk("bstus_fall_edge0", E_NOP);
    tick();
    chk("bstus_fall_edge1", E_NOP);
    tick();
    chk("bstus_fall_edge2", E_HOLD);
    op(6'b000111, 1'b1); chk("bat_bc1_after_fall", E_NOP);

    // Back to 1, then drop reset mid-cycle: bstus_q clears without an edge.
    Bstus = 1'b1;
    tick();
    tick();
    chk("bstus_rise_edge2", E_HOLD);
    #2;
    nReset = 1'b0;
    chk("async_reset_bc1", E_NOP);
    op(6'b000111, 1'b0); chk("async_reset_bc0", E_HOLD);
    op(6'b000010, 1'b0); chk("sub_in_reset", E_SUB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
